// File: rtl/qea_state_unloader.sv
// Walks the QEA state RAM from address 0 and streams one complex amplitude per beat,
// tagged with its basis index. Define QEA_UNLOAD_SKIP_ZERO_EN to skip zero amplitudes.
module qea_state_unloader #(
  parameter int PE_NUM_WIDTH     = 2,
  parameter int PE_NUM           = 4,
  parameter int DATA_WIDTH       = 32,
  parameter int STATE_DATA_WIDTH = 64,
  parameter int STATE_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH   = 6,
  parameter int RD_LATENCY       = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]                i_qbit_num,
  output logic                                     o_state_ena,
  output logic [PE_NUM-1:0]                        o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]              o_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]       i_state_dout,
  output logic                                     o_amp_valid,
  input  logic                                     i_amp_ready,
  output logic [STATE_DATA_WIDTH-1:0]              o_amp_data,
  output logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_amp_index,
  output logic                                     o_amp_last,
  output logic                                     o_busy,
  output logic                                     o_done
);

  localparam int WORD_W = PE_NUM * STATE_DATA_WIDTH;
  localparam int CNT_W  = STATE_ADDR_WIDTH + 1;
  localparam logic [PE_NUM_WIDTH-1:0] LAST_LANE = PE_NUM_WIDTH'(PE_NUM - 1);

  if (STATE_DATA_WIDTH != 2 * DATA_WIDTH || PE_NUM != (1 << PE_NUM_WIDTH) ||
      RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_params
    $error("qea_state_unloader: inconsistent parameters");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t                      state_q, state_n;
  logic [CNT_W-1:0]            w_cnt, rd_addr;
  logic [RD_LATENCY-1:0]       rd_pipe;
  logic [STATE_ADDR_WIDTH-1:0] ret_addr, ret_addr_n;
  logic                        hold_valid, hold_valid_n, pf_valid, pf_valid_n;
  logic [WORD_W-1:0]           hold_word, hold_word_n, pf_word, pf_word_n;
  logic [STATE_ADDR_WIDTH-1:0] hold_addr, hold_addr_n, pf_addr, pf_addr_n;
  logic [PE_NUM_WIDTH-1:0]     lane, lane_n;
  logic [STATE_DATA_WIDTH-1:0] cur_amp;
  logic is_last, skip, amp_valid, xfer, adv, word_done, hold_free, ret_valid;
  logic flight_after, rd_issue;

  function automatic logic [CNT_W-1:0] word_count(input logic [MAX_QBIT_WIDTH-1:0] q);
    int qi;
    qi = int'(q);
    if (qi <= PE_NUM_WIDTH) return CNT_W'(1);
    if (qi >= STATE_ADDR_WIDTH + PE_NUM_WIDTH) return CNT_W'(1) << STATE_ADDR_WIDTH;
    return CNT_W'(1) << (qi - PE_NUM_WIDTH);
  endfunction

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cur_amp   = hold_word[WORD_W-1 - int'(lane)*STATE_DATA_WIDTH -: STATE_DATA_WIDTH];
    is_last   = hold_valid && (lane == LAST_LANE) &&
                ({1'b0, hold_addr} == w_cnt - CNT_W'(1));
`ifdef QEA_UNLOAD_SKIP_ZERO_EN
    skip      = hold_valid && (cur_amp == '0) && !is_last;
`else
    skip      = 1'b0;
`endif
    amp_valid = hold_valid && !skip;
    xfer      = amp_valid && i_amp_ready;
    adv       = xfer || skip;
    word_done = adv && (lane == LAST_LANE);
    hold_free = !hold_valid || word_done;
    ret_valid = rd_pipe[RD_LATENCY-1];

    hold_valid_n = hold_valid;
    hold_word_n  = hold_word;
    hold_addr_n  = hold_addr;
    pf_valid_n   = pf_valid;
    pf_word_n    = pf_word;
    pf_addr_n    = pf_addr;
    lane_n       = adv ? lane + 1'b1 : lane;
    ret_addr_n   = ret_valid ? ret_addr + 1'b1 : ret_addr;

    // Returning data bypasses the prefetch slot whenever the holding register drains this cycle.
    if (hold_free) begin
      if (pf_valid) begin
        hold_valid_n = 1'b1;
        hold_word_n  = pf_word;
        hold_addr_n  = pf_addr;
        pf_valid_n   = 1'b0;
      end else if (ret_valid) begin
        hold_valid_n = 1'b1;
        hold_word_n  = i_state_dout;
        hold_addr_n  = ret_addr;
      end else begin
        hold_valid_n = 1'b0;
      end
    end
    if (ret_valid && !(hold_free && !pf_valid)) begin
      pf_valid_n = 1'b1;
      pf_word_n  = i_state_dout;
      pf_addr_n  = ret_addr;
    end

    // Reads whose data lands on this edge no longer count as in flight.
    flight_after = o_state_ena;
    for (int i = 0; i < RD_LATENCY - 1; i++) flight_after |= rd_pipe[i];
    rd_issue = (state_q == S_RUN) && !pf_valid_n && !flight_after && (rd_addr < w_cnt);
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_n = S_RUN;
      S_RUN:   if (xfer && is_last) state_n = S_FIN;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_cnt         <= '0;
      rd_addr       <= '0;
      rd_pipe       <= '0;
      ret_addr      <= '0;
      hold_valid    <= 1'b0;
      hold_word     <= '0;
      hold_addr     <= '0;
      pf_valid      <= 1'b0;
      pf_word       <= '0;
      pf_addr       <= '0;
      lane          <= '0;
      o_state_ena   <= 1'b0;
      o_state_addra <= '0;
    end else begin
      rd_pipe[0] <= o_state_ena;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      hold_valid <= hold_valid_n;
      hold_word  <= hold_word_n;
      hold_addr  <= hold_addr_n;
      pf_valid   <= pf_valid_n;
      pf_word    <= pf_word_n;
      pf_addr    <= pf_addr_n;
      lane       <= lane_n;
      if (state_q == S_IDLE && i_start) begin
        w_cnt         <= word_count(i_qbit_num);
        rd_addr       <= CNT_W'(1);
        ret_addr      <= '0;
        o_state_ena   <= 1'b1;
        o_state_addra <= '0;
      end else begin
        ret_addr    <= ret_addr_n;
        o_state_ena <= rd_issue;
        if (rd_issue) begin
          o_state_addra <= rd_addr[STATE_ADDR_WIDTH-1:0];
          rd_addr       <= rd_addr + 1'b1;
        end
      end
    end
  end

  assign o_state_wea = '0;
  assign o_amp_valid = amp_valid;
  assign o_amp_data  = hold_valid ? cur_amp : '0;
  assign o_amp_index = hold_valid ? {hold_addr, lane} : '0;
  assign o_amp_last  = is_last;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_FIN);

endmodule

// File: tb/tb_qea_state_unloader.sv
// Scoreboard bench for qea_state_unloader: a sparse RAM model feeds the DUT, a
// reference model queues expected beats, and a negedge monitor pops and compares.
module tb_qea_state_unloader;

  localparam int PNW   = 2;
  localparam int PE    = 4;
  localparam int SDW   = 64;
  localparam int SAW   = 16;
  localparam int MQW   = 6;
  localparam int RDL   = 1;
  localparam int IDXW  = SAW + PNW;
  localparam int WORDW = PE * SDW;
`ifdef QEA_UNLOAD_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_start = 1'b0;
  logic [MQW-1:0]   i_qbit_num = '0;
  logic             o_state_ena;
  logic [PE-1:0]    o_state_wea;
  logic [SAW-1:0]   o_state_addra;
  logic [WORDW-1:0] i_state_dout;
  logic             o_amp_valid;
  logic             i_amp_ready = 1'b1;
  logic [SDW-1:0]   o_amp_data;
  logic [IDXW-1:0]  o_amp_index;
  logic             o_amp_last;
  logic             o_busy;
  logic             o_done;

  qea_state_unloader #(
    .PE_NUM_WIDTH(PNW), .PE_NUM(PE), .DATA_WIDTH(SDW/2), .STATE_DATA_WIDTH(SDW),
    .STATE_ADDR_WIDTH(SAW), .MAX_QBIT_WIDTH(MQW), .RD_LATENCY(RDL)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_qbit_num(i_qbit_num),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
    .i_state_dout(i_state_dout), .o_amp_valid(o_amp_valid), .i_amp_ready(i_amp_ready),
    .o_amp_data(o_amp_data), .o_amp_index(o_amp_index), .o_amp_last(o_amp_last),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SDW-1:0]  data;
    logic [IDXW-1:0] idx;
    logic            last;
  } beat_t;

  bit [WORDW-1:0] mem [int unsigned];
  beat_t          exp_q [$];
  int n_vec = 0, n_err = 0;
  int beat_cnt = 0, done_cnt = 0, cyc = 0, first_cyc = -1, last_cyc = 0;
  int ram_reads = 0, rdy_mode = 0, rdy_cyc = 0;
  logic [SAW-1:0] ram_last_addr = '0;

  function automatic logic [WORDW-1:0] rd_mem(input int unsigned a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  function automatic int words(input int q);
    if (q <= PNW) return 1;
    if (q >= SAW + PNW) return 1 << SAW;
    return 1 << (q - PNW);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural state RAM: registered read with RDL cycles of latency.
  logic [WORDW-1:0] ram_pipe [RDL];
  always @(posedge clk) begin
    if (o_state_ena) begin
      ram_reads     <= ram_reads + 1;
      ram_last_addr <= o_state_addra;
      ram_pipe[0]   <= rd_mem(int'(o_state_addra));
    end
    for (int i = 1; i < RDL; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign i_state_dout = ram_pipe[RDL-1];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy_cyc++;
      case (rdy_mode)
        0:       i_amp_ready = 1'b1;
        1:       i_amp_ready = (rdy_cyc % 3 == 0);
        default: i_amp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability and done timing.
  initial begin
    bit have_stall;
    int post_last;
    logic [SDW+IDXW:0] held;
    beat_t e;
    have_stall = 0;
    post_last  = 0;
    held       = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        have_stall = 0;
        post_last  = 0;
      end else begin
        if (post_last == 2) begin
          check("busy_drop", {o_done, o_busy}, 2'b00);
          post_last = 0;
        end else if (post_last == 1) begin
          check("done_pulse", {o_done, o_busy}, 2'b11);
          post_last = 2;
        end
        if (o_done) done_cnt++;
        if (have_stall)
          check("stall_stable", {o_amp_valid, o_amp_data, o_amp_index, o_amp_last}, {1'b1, held});
        have_stall = o_amp_valid && !i_amp_ready;
        held       = {o_amp_data, o_amp_index, o_amp_last};
        if (o_amp_valid && i_amp_ready) begin
          beat_cnt++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: index %0h data %0h with no beat outstanding",
                     o_amp_index, o_amp_data);
          end else begin
            e = exp_q.pop_front();
            check("beat", {o_amp_data, o_amp_index, o_amp_last}, {e.data, e.idx, e.last});
            if (o_amp_last) post_last = 1;
          end
        end
      end
    end
  end

  task automatic push_expected(input int q);
    int w;
    beat_t b;
    logic [WORDW-1:0] word;
    w = words(q);
    for (int a = 0; a < w; a++) begin
      word = rd_mem(a);
      for (int k = 0; k < PE; k++) begin
        b.data = word[WORDW-1-k*SDW -: SDW];
        b.idx  = IDXW'(a * PE + k);
        b.last = (a == w - 1) && (k == PE - 1);
        if (!(SKIP && b.data == '0 && !b.last)) exp_q.push_back(b);
      end
    end
  endtask

  task automatic fill_mem(input int q);
    logic [WORDW-1:0] word;
    mem.delete();
    for (int a = 0; a < words(q); a++) begin
      for (int k = 0; k < PE; k++)
        word[WORDW-1-k*SDW -: SDW] = ($urandom_range(0, 2) == 0) ? 64'h0 : {$urandom, $urandom};
      mem[a] = word;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {o_state_ena, o_state_wea, o_state_addra, o_amp_valid, o_amp_data,
                 o_amp_index, o_amp_last, o_busy, o_done}, '0);
  endtask

  task automatic pulse_start(input int q);
    @(posedge clk);
    #1 i_qbit_num = MQW'(q);
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    i_qbit_num = MQW'($urandom);
  endtask

  task automatic run_readout(input int q, input int mode, input bit mid_start, input bit chk_lat);
    int w, reads0, lat, n;
    w         = words(q);
    rdy_mode  = mode;
    push_expected(q);
    done_cnt  = 0;
    first_cyc = -1;
    reads0    = ram_reads;
    pulse_start(q);
    @(negedge clk);
    check("start_cycle", {o_busy, o_state_ena, o_state_addra}, {1'b1, 1'b1, 16'h0});
    lat = 1;
    while (!o_amp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (chk_lat) check("first_valid_latency", lat, 2 + RDL);
    n = 0;
    while (o_busy && n < 4 * w * PE + 100) begin
      @(negedge clk);
      n++;
      i_start = mid_start && (n == 20);
    end
    i_start = 1'b0;
    check("readout_completes", o_busy, 1'b0);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("done_once", done_cnt, 1);
    if (mode == 0 && !SKIP) check("no_bubbles", last_cyc - first_cyc + 1, w * PE);
    if (q <= PNW) check("subword_single_read", {ram_reads - reads0, ram_last_addr}, {32'd1, 16'h0});
  endtask

  initial begin
    int b0, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_values");
    @(posedge clk);
    #1 rst = 1'b0;

    // 13-qubit basis state |0>
    mem.delete();
    mem[0] = {64'h4000_0000_0000_0000, 192'h0};
    run_readout(13, 0, 1'b0, 1'b1);

    fill_mem(4);
    run_readout(4, 1, 1'b0, 1'b0);

    fill_mem(2);
    run_readout(2, 2, 1'b0, 1'b0);
    fill_mem(0);
    run_readout(0, 0, 1'b0, 1'b0);

    fill_mem(6);
    run_readout(6, 0, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      int q;
      q = $urandom_range(0, 9);
      fill_mem(q);
      run_readout(q, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset at beat 100 of a long run, then restart from index 0.
    fill_mem(9);
    push_expected(9);
    rdy_mode = 2;
    b0 = beat_cnt;
    pulse_start(9);
    n = 0;
    while (beat_cnt - b0 < 100 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached_beat_100", beat_cnt - b0 >= 100, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_mid_run");
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    fill_mem(5);
    mem[0][WORDW-1 -: SDW] = 64'h0123_4567_89ab_cdef;
    run_readout(5, 0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
